// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor width, request record, reject codes and issue FSM encoding
package elevator_pkg;
    localparam int FLOOR_W = 3;

    typedef struct packed {
        logic [FLOOR_W-1:0] src;
        logic [FLOOR_W-1:0] dest;
        logic               dir;
    } req_t;

    localparam logic [1:0] REJ_NONE    = 2'b00;
    localparam logic [1:0] REJ_INVALID = 2'b01;
    localparam logic [1:0] REJ_FULL    = 2'b10;
    localparam logic [1:0] REJ_DUP     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/request_queue_if.sv
// request_queue_if: passenger-request input and controller-issue output bundle
interface request_queue_if;
    import elevator_pkg::*;
    logic               req_valid;
    logic [FLOOR_W-1:0] req_src;
    logic [FLOOR_W-1:0] req_dest;
    logic               req_dir;
    logic               ctrl_ready;
    logic               set_pulse;
    logic [FLOOR_W-1:0] set_src;
    logic [FLOOR_W-1:0] set_dest;
    logic               set_dir;
    logic [3:0]         count;
    logic               full;
    logic               empty;
    logic               rej;
    logic [1:0]         rej_code;

    modport slave (
        input  req_valid, req_src, req_dest, req_dir, ctrl_ready,
        output set_pulse, set_src, set_dest, set_dir, count, full, empty, rej, rej_code
    );

    modport master (
        output req_valid, req_src, req_dest, req_dir, ctrl_ready,
        input  set_pulse, set_src, set_dest, set_dir, count, full, empty, rej, rej_code
    );
endinterface

// File: rtl/req_fifo.sv
// req_fifo: circular request store with a combinational duplicate-compare port
module req_fifo
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  req_t       i_data,
    input  logic       i_pop,
    input  req_t       i_cmp,
    output req_t       o_head,
    output logic       o_match,
    output logic [3:0] o_count,
    output logic       o_full,
    output logic       o_empty
);
    localparam int PW = $clog2(DEPTH);

    req_t             r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [3:0]       r_count;
    logic [DEPTH-1:0] w_hit;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_hit[g] = r_vld[g] && (r_mem[g] == i_cmp);
    end

    assign w_set   = DEPTH'(i_push) << r_wr;
    assign w_clr   = DEPTH'(i_pop) << r_rd;
    assign o_match = |w_hit;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == 4'(DEPTH);
    assign o_empty = r_count == 4'd0;

    // Pointers, occupancy flags and count; push and pop may land on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {3'b0, i_push} - {3'b0, i_pop};
            r_vld   <= (r_vld & ~w_clr) | w_set;
        end
    end

    // Entry storage; stale slots are masked by r_vld so no reset is needed
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/request_queue.sv
// request_queue: validates passenger requests, queues them and strobes them to the controller
module request_queue
    import elevator_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLOORS = 8
) (
    input  logic           clk,
    input  logic           rst,
    request_queue_if.slave bus
);
    localparam logic [FLOOR_W:0] L_FLOORS = 4'(FLOORS);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_rej_code;
    logic [1:0] w_rej_code;
    req_t       r_set;
    req_t       w_req;
    req_t       w_head;
    logic       w_invalid;
    logic       w_push;
    logic       w_pop;
    logic       w_match;
    logic       w_full;
    logic       w_empty;
    logic [3:0] w_count;

    assign w_req     = '{src: bus.req_src, dest: bus.req_dest, dir: bus.req_dir};
    assign w_invalid = (bus.req_src == bus.req_dest) ||
                       ({1'b0, bus.req_src} >= L_FLOORS) ||
                       ({1'b0, bus.req_dest} >= L_FLOORS) ||
                       (bus.req_dir && (bus.req_src > bus.req_dest)) ||
                       (!bus.req_dir && (bus.req_src < bus.req_dest));
    assign w_push    = bus.req_valid && !w_invalid && !w_full && !w_match;
    assign w_rej_code = !bus.req_valid ? REJ_NONE :
                        w_invalid      ? REJ_INVALID :
                        w_full         ? REJ_FULL :
                        w_match        ? REJ_DUP : REJ_NONE;

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .i_cmp   (w_req),
        .o_head  (w_head),
        .o_match (w_match),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Issue sequencing: IDLE waits for work, ISSUE strobes and pops, GAP enforces spacing
    always_comb begin
        w_next = S_IDLE;
        w_pop  = 1'b0;
        w_next = (r_state == S_ISSUE) ? S_GAP :
                 (r_state == S_IDLE && !w_empty && bus.ctrl_ready) ? S_ISSUE : S_IDLE;
        w_pop  = r_state == S_ISSUE;
    end

    // FSM state, registered reject status and the issued-request holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rej_code <= REJ_NONE;
            r_set      <= '0;
        end else begin
            r_state    <= w_next;
            r_rej_code <= w_rej_code;
            if (w_next == S_ISSUE) r_set <= w_head;
        end
    end

    assign bus.set_pulse = r_state == S_ISSUE;
    assign bus.set_src   = r_set.src;
    assign bus.set_dest  = r_set.dest;
    assign bus.set_dir   = r_set.dir;
    assign bus.count     = w_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.rej       = |r_rej_code;
    assign bus.rej_code  = r_rej_code;
endmodule
